seq_shift_unit: RTL

//   Parametrised multi-cycle shift/rotate unit; next generation of the 8-bit rotate register.

---
 rtl/seq_shift_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: loads a word on start, then moves it one bit
// per clock for num steps in the selected mode and direction, with a start/busy/done handshake.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] num,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // One 1-bit step; the bit entering at the vacated end depends on mode.
    function automatic logic [WIDTH-1:0] step_once(
        input logic [WIDTH-1:0] val,
        input logic             right,
        input logic [1:0]       md,
        input logic             fill_in
    );
        logic edge_bit;
        if (right) begin
            case (md)
                2'b00:   edge_bit = val[0];
                2'b01:   edge_bit = 1'b0;
                2'b10:   edge_bit = val[WIDTH-1];
                2'b11:   edge_bit = fill_in;
                default: edge_bit = 1'b0;
            endcase
            step_once = {edge_bit, val[WIDTH-1:1]};
        end else begin
            case (md)
                2'b00:   edge_bit = val[WIDTH-1];
                2'b11:   edge_bit = fill_in;
                default: edge_bit = 1'b0;
            endcase
            step_once = {val[WIDTH-2:0], edge_bit};
        end
    endfunction

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        count_d = count_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    dout_d  = din;
                    count_d = num;
                    dir_d   = dir;
                    mode_d  = mode;
                    state_d = (num == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                dout_d  = step_once(dout_q, dir_q, mode_q, sin);
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; busy/done track the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dout_q  <= {WIDTH{1'b0}};
            count_q <= CNT_ZERO;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
